perc_seq: RTL

Sequencing controller for the 4-bit-weight threshold perceptron datapath. Accepts one input vector per valid/ready handshake and walks a single shared multiply-accumulate across the `WIDTH` inputs, one bit per cycle. Compares the sum against a threshold and presents the result on a valid/ready output. Owns the weight register file, which is writable between inferences, and optionally runs the perceptron learning rule.

---
 rtl/perc_seq.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/perc_seq.sv
// Sequencing controller for a threshold perceptron: one shared MAC walks the input bits serially.
// Optional on-line learning rule is compiled in with `define PERC_TRAIN_EN.
module perc_seq #(
  parameter int unsigned WIDTH  = 4,
  parameter logic [7:0]  THRESH = 8'd10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] data_in,
`ifdef PERC_TRAIN_EN
  input  logic             label,
`endif
  input  logic             w_we,
  input  logic [3:0]       w_addr,
  input  logic [3:0]       w_data,
  output logic             w_err,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             data_out,
  output logic [7:0]       sum_out
);

`ifdef PERC_TRAIN_EN
  typedef enum logic [1:0] {StIdle, StAcc, StDone, StUpdate} state_e;
`else
  typedef enum logic [1:0] {StIdle, StAcc, StDone} state_e;
`endif

  localparam logic [3:0] LastIdx = 4'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [7:0]       sum_q, sum_d;
  logic [3:0]       idx_q, idx_d;
  logic [WIDTH-1:0] din_q, din_d;
  logic [3:0]       w_q [WIDTH];
  logic [3:0]       w_d [WIDTH];
  logic             w_err_q, w_err_d;
  logic             w_ok;
  logic             above;
  logic [3:0]       term;
`ifdef PERC_TRAIN_EN
  logic             label_q, label_d;
`endif

  assign w_ok      = (state_q == StIdle) && ({1'b0, w_addr} < 5'(WIDTH));
  assign above     = (sum_q >= THRESH);
  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StDone);
  assign data_out  = out_valid && above;
  assign sum_out   = out_valid ? sum_q : 8'd0;
  assign w_err     = w_err_q;

  // Weight selected by the current bit index, gated by that input bit.
  always_comb begin
    term = 4'd0;
    for (int i = 0; i < WIDTH; i++) begin
      if (idx_q == 4'(i) && din_q[i]) term = w_q[i];
    end
  end

  always_comb begin
    state_d = state_q;
    sum_d   = sum_q;
    idx_d   = idx_q;
    din_d   = din_q;
    w_d     = w_q;
    w_err_d = w_we && !w_ok;
`ifdef PERC_TRAIN_EN
    label_d = label_q;
`endif
    // The write lands in the same edge as an accept, so the new inference sees it.
    if (w_we && w_ok) begin
      for (int i = 0; i < WIDTH; i++) begin
        if (w_addr == 4'(i)) w_d[i] = w_data;
      end
    end
    case (state_q)
      StIdle: begin
        if (in_valid) begin
          din_d   = data_in;
          sum_d   = 8'd0;
          idx_d   = 4'd0;
          state_d = StAcc;
`ifdef PERC_TRAIN_EN
          label_d = label;
`endif
        end
      end
      StAcc: begin
        sum_d = sum_q + {4'd0, term};
        idx_d = idx_q + 4'd1;
        if (idx_q == LastIdx) state_d = StDone;
      end
      StDone: begin
        if (out_ready) begin
          state_d = StIdle;
`ifdef PERC_TRAIN_EN
          if (above != label_q) state_d = StUpdate;
`endif
        end
      end
`ifdef PERC_TRAIN_EN
      StUpdate: begin
        for (int i = 0; i < WIDTH; i++) begin
          if (din_q[i]) begin
            if (label_q) w_d[i] = (w_q[i] == 4'hf) ? 4'hf : w_q[i] + 4'd1;
            else         w_d[i] = (w_q[i] == 4'h0) ? 4'h0 : w_q[i] - 4'd1;
          end
        end
        state_d = StIdle;
      end
`endif
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      sum_q   <= 8'd0;
      idx_q   <= 4'd0;
      din_q   <= '0;
      w_err_q <= 1'b0;
      for (int i = 0; i < WIDTH; i++) w_q[i] <= 4'(1 << (i % 4));
`ifdef PERC_TRAIN_EN
      label_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      sum_q   <= sum_d;
      idx_q   <= idx_d;
      din_q   <= din_d;
      w_err_q <= w_err_d;
      w_q     <= w_d;
`ifdef PERC_TRAIN_EN
      label_q <= label_d;
`endif
    end
  end

endmodule
